traffic_phase_controller: RTL and testbench
===========================================

# traffic_phase_controller

Parametrised two-road intersection controller with programmable phase durations. It adds all-red clearance intervals, latched pedestrian requests with walk outputs, early green termination on cross-traffic demand, and a safe night-flash mode. It drives the north-south and east-west signal heads directly and exposes its phase for status logging.

## Interface
- GREEN_CYCLES, 50000: maximum green duration per direction, in clocks.
- MIN_GREEN_CYCLES, 10000: minimum green before a cross-direction pedestrian request may end the green early.
- YELLOW_CYCLES, 10000: yellow duration.
- ALLRED_CYCLES, 2000: all-red clearance after every yellow, and after reset.
- WALK_CYCLES, 8000: walk-signal duration at the start of a served green.
- FLASH_CYCLES, 25000: half-period of the flash blink.
- TIMER_W, 16: phase timer width.
- Legal ranges: all durations ≥1 and < 2^TIMER_W; WALK_CYCLES ≤ MIN_GREEN_CYCLES ≤ GREEN_CYCLES.

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ped_req_ns  in  1  pedestrian request to cross with NS traffic; single-cycle pulse or level
- ped_req_ew  in  1  pedestrian request to cross with EW traffic
- flash_en  in  1  night-flash mode request, level-sensitive
- ns_light  out  3  {red, yellow, green}: 100 = red, 010 = yellow, 001 = green, 000 = dark
- ew_light  out  3  same encoding
- walk_ns  out  1  NS pedestrian walk
- walk_ew  out  1  EW pedestrian walk
- phase  out  3  current state encoding: 0 NS_G, 1 NS_Y, 2 AR_NS, 3 EW_G, 4 EW_Y, 5 AR_EW, 6 FLASH

## Operation
- States:
  - AR_EW: all-red, leads to NS_G. This is the reset state.
  - NS_G, then NS_Y, then AR_NS.
  - AR_NS: all-red, leads to EW_G.
  - EW_G, then EW_Y, then AR_EW.
  - FLASH.
- Each timed state occupies exactly its duration in clocks. The timer clears on every state entry and counts 0..N-1. The transition occurs on the edge where timer == N-1.
- Pending bits pend_ns and pend_ew:
  - Set by the corresponding ped_req while it is high.
  - Cleared on the edge entering that direction's green; a request in that same cycle is still cleared.
  - Effective demand = pend | ped_req in the same cycle.
- Walk:
  - On entry to NS_G with pend_ns effective set, walk_ns is high for the first WALK_CYCLES of NS_G, then low.
  - walk_ew behaves the same way for EW_G.
  - Walk is never high outside its green.
- Early termination: NS_G leaves to NS_Y at the end of any cycle where (timer == GREEN-1) or (effective pend_ew and timer ≥ MIN_GREEN-1). EW_G follows the same rule with pend_ns.
- Flash mode:
  - flash_en high in a green forces that direction's yellow at the next edge. MIN_GREEN does not apply.
  - flash_en high in a yellow lets the yellow complete normally, then the all-red completes normally.
  - When an all-red completes with flash_en high, the next state is FLASH, not the next green.
  - In FLASH, ns_light alternates 010/000 and ew_light alternates 100/000. Both start lit and toggle every FLASH_CYCLES. Walks are low.
  - In FLASH, pending bits keep latching.
  - flash_en low in FLASH moves to AR_EW, which runs a full ALLRED_CYCLES and then goes to NS_G.
- Light and phase decode:
  - NS_G: ns_light = 001, ew_light = 100.
  - NS_Y: ns_light = 010, ew_light = 100.
  - EW_G: ns_light = 100, ew_light = 001.
  - EW_Y: ns_light = 100, ew_light = 010.
  - Both all-red states: 100/100.
- Safety invariant: ns_light and ew_light are never both non-red, except in FLASH.

## Timing
- Reset values:
  - State AR_EW, timer 0, pend_ns = pend_ew = 0, flash toggle 0.
  - ns_light = ew_light = 100, walk_ns = walk_ew = 0, phase = 5.
- Outputs are registered and change on the same edge as the state register. There are no combinational paths from inputs to outputs.
- After rst deasserts, the first edge is timer cycle 0 of AR_EW. NS_G is visible after ALLRED_CYCLES edges.
- Asserting rst mid-phase returns all outputs to their reset values immediately (asynchronously). Pending requests are lost.
- The timer never wraps; parameter ranges guarantee this.

## Test plan
Parameters for all scenarios: GREEN 10, MIN_GREEN 4, YELLOW 3, ALLRED 2, WALK 2, FLASH 2.
- Free run, no requests: after reset release, lights are 100/100 ×2 cycles, NS_G ×10, NS_Y ×3, AR ×2, EW_G ×10, EW_Y ×3, AR ×2. Period is 30; walks stay 0.
- ped_req_ew pulse at NS_G timer 1: NS_G lasts 4 cycles total, then NS_Y. In the following EW_G, walk_ew = 1 for 2 cycles and pend_ew clears.
- ped_req_ew pulse at NS_G timer 6: NS_Y starts on the next edge.
- ped_req_ns during NS_G: not served early. It is cleared only on the next NS_G entry, which then shows walk_ns for 2 cycles.
- flash_en rises at EW_G timer 3: EW_Y ×3, AR ×2, then FLASH. ns_light shows 010,010,000,000,…; ew_light shows 100,100,000,000,… .
- flash_en falls while in FLASH: AR_EW ×2 (100/100), then NS_G. Separately, rst asserted mid NS_Y: outputs are 100/100 with walks 0 immediately.

Source files
------------

// File: rtl/traffic_phase_controller.sv
// Two-road intersection controller: timed green/yellow/all-red phases,
// latched pedestrian requests with walk outputs, and night-flash mode.
module traffic_phase_controller #(
    parameter int GREEN_CYCLES     = 50000,
    parameter int MIN_GREEN_CYCLES = 10000,
    parameter int YELLOW_CYCLES    = 10000,
    parameter int ALLRED_CYCLES    = 2000,
    parameter int WALK_CYCLES      = 8000,
    parameter int FLASH_CYCLES     = 25000,
    parameter int TIMER_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    input  logic       flash_en,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR_NS = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR_EW = 3'd5,
        FLASH = 3'd6
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    localparam logic [TIMER_W-1:0] G_LAST  = TIMER_W'(GREEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] MG_LAST = TIMER_W'(MIN_GREEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] Y_LAST  = TIMER_W'(YELLOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] AR_LAST = TIMER_W'(ALLRED_CYCLES - 1);
    localparam logic [TIMER_W-1:0] FL_LAST = TIMER_W'(FLASH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WALK_N  = TIMER_W'(WALK_CYCLES);

    state_t             state, state_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic               pend_ns, pend_ns_n;
    logic               pend_ew, pend_ew_n;
    logic               tog, tog_n;
    logic               walk_ns_n, walk_ew_n;
    logic [2:0]         ns_n, ew_n;
    logic               eff_ns, eff_ew, entering;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= AR_EW;
            timer    <= '0;
            pend_ns  <= 1'b0;
            pend_ew  <= 1'b0;
            tog      <= 1'b0;
            walk_ns  <= 1'b0;
            walk_ew  <= 1'b0;
            ns_light <= RED;
            ew_light <= RED;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            pend_ns  <= pend_ns_n;
            pend_ew  <= pend_ew_n;
            tog      <= tog_n;
            walk_ns  <= walk_ns_n;
            walk_ew  <= walk_ew_n;
            ns_light <= ns_n;
            ew_light <= ew_n;
        end
    end

    assign phase  = state;
    assign eff_ns = pend_ns | ped_req_ns;
    assign eff_ew = pend_ew | ped_req_ew;

    always_comb begin
        state_n = state;
        unique case (state)
            AR_EW: if (timer == AR_LAST) state_n = flash_en ? FLASH : NS_G;
            NS_G:
                if (flash_en || timer == G_LAST ||
                    (eff_ew && timer >= MG_LAST))
                    state_n = NS_Y;
            NS_Y:  if (timer == Y_LAST) state_n = AR_NS;
            AR_NS: if (timer == AR_LAST) state_n = flash_en ? FLASH : EW_G;
            EW_G:
                if (flash_en || timer == G_LAST ||
                    (eff_ns && timer >= MG_LAST))
                    state_n = EW_Y;
            EW_Y:  if (timer == Y_LAST) state_n = AR_EW;
            FLASH: if (!flash_en) state_n = AR_EW;
            default: state_n = AR_EW;
        endcase
    end

    always_comb begin
        entering = (state_n != state);
        timer_n  = timer + TIMER_W'(1);
        tog_n    = tog;
        if (entering) begin
            timer_n = '0;
            tog_n   = 1'b0;
        end else if (state == FLASH && timer == FL_LAST) begin
            timer_n = '0;
            tog_n   = ~tog;
        end

        // A request arriving on the green-entry edge is absorbed by that green
        pend_ns_n = eff_ns;
        pend_ew_n = eff_ew;
        if (entering && state_n == NS_G) pend_ns_n = 1'b0;
        if (entering && state_n == EW_G) pend_ew_n = 1'b0;

        walk_ns_n = 1'b0;
        walk_ew_n = 1'b0;
        if (state_n == NS_G)
            walk_ns_n = entering ? eff_ns : (walk_ns && timer_n < WALK_N);
        if (state_n == EW_G)
            walk_ew_n = entering ? eff_ew : (walk_ew && timer_n < WALK_N);

        ns_n = RED;
        ew_n = RED;
        unique case (state_n)
            NS_G:  ns_n = GRN;
            NS_Y:  ns_n = YEL;
            EW_G:  ew_n = GRN;
            EW_Y:  ew_n = YEL;
            FLASH: begin
                ns_n = tog_n ? OFF : YEL;
                ew_n = tog_n ? OFF : RED;
            end
            default: begin
                ns_n = RED;
                ew_n = RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed scoreboard bench for traffic_phase_controller using the
// small test-plan parameter set.
module tb_traffic_phase_controller;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] D = 3'b000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ped_req_ns = 1'b0;
    logic       ped_req_ew = 1'b0;
    logic       flash_en = 1'b0;
    logic [2:0] ns_light, ew_light, phase;
    logic       walk_ns, walk_ew;

    int total = 0;
    int bad   = 0;
    int step  = 0;
    logic [10:0] q[$];

    always #5 clk = ~clk;

    traffic_phase_controller #(
        .GREEN_CYCLES(10),
        .MIN_GREEN_CYCLES(4),
        .YELLOW_CYCLES(3),
        .ALLRED_CYCLES(2),
        .WALK_CYCLES(2),
        .FLASH_CYCLES(2),
        .TIMER_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ped_req_ns(ped_req_ns),
        .ped_req_ew(ped_req_ew),
        .flash_en(flash_en),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .walk_ns(walk_ns),
        .walk_ew(walk_ew),
        .phase(phase)
    );

    function automatic logic [10:0] obs();
        return {phase, ns_light, ew_light, walk_ns, walk_ew};
    endfunction

    task automatic check(input string tag, input logic [10:0] got,
                         input logic [10:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s step=%0d got=%h exp=%h", tag, step, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] ph, input logic [2:0] n,
                        input logic [2:0] e, input logic wn,
                        input logic we, input int k);
        for (int i = 0; i < k; i++) q.push_back({ph, n, e, wn, we});
    endtask

    task automatic ns_g(input int k, input logic wn);
        push(3'd0, G, R, wn, 1'b0, k);
    endtask
    task automatic ns_y(input int k);
        push(3'd1, Y, R, 1'b0, 1'b0, k);
    endtask
    task automatic ar_ns(input int k);
        push(3'd2, R, R, 1'b0, 1'b0, k);
    endtask
    task automatic ew_g(input int k, input logic we);
        push(3'd3, R, G, 1'b0, we, k);
    endtask
    task automatic ew_y(input int k);
        push(3'd4, R, Y, 1'b0, 1'b0, k);
    endtask
    task automatic ar_ew(input int k);
        push(3'd5, R, R, 1'b0, 1'b0, k);
    endtask
    task automatic fl(input logic lit, input int k);
        push(3'd6, lit ? Y : D, lit ? R : D, 1'b0, 1'b0, k);
    endtask

    task automatic run(input int k);
        logic [10:0] exp;
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            step++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL underflow step=%0d got=%h exp=none", step, obs());
            end else begin
                exp = q.pop_front();
                check("seq", obs(), exp);
            end
            total++;
            assert (phase == 3'd6 || ns_light == R || ew_light == R) else begin
                bad++;
                $error("FAIL safety step=%0d got=%b/%b exp=one red",
                       step, ns_light, ew_light);
            end
        end
    endtask

    initial begin
        #3 rst = 1'b1;
        #2;
        check("rst_async", obs(), {3'd5, R, R, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", obs(), {3'd5, R, R, 1'b0, 1'b0});
        rst = 1'b0;

        // free run
        ar_ew(1); ns_g(10, 0); ns_y(3); ar_ns(2);
        ew_g(10, 0); ew_y(3); ar_ew(2);
        run(31);

        // EW request at NS_G timer 1
        ns_g(4, 0); ns_y(3); ar_ns(2);
        ew_g(2, 1); ew_g(8, 0); ew_y(3); ar_ew(2);
        run(2);
        ped_req_ew = 1'b1;
        run(1);
        ped_req_ew = 1'b0;
        run(21);

        // EW request at NS_G timer 6
        ns_g(7, 0); ns_y(3); ar_ns(2);
        ew_g(2, 1); ew_g(8, 0); ew_y(3); ar_ew(2);
        run(7);
        ped_req_ew = 1'b1;
        run(1);
        ped_req_ew = 1'b0;
        run(19);

        // NS request during NS_G: served at the next NS_G
        ns_g(10, 0); ns_y(3); ar_ns(2);
        ew_g(4, 0); ew_y(3); ar_ew(2);
        ns_g(2, 1); ns_g(8, 0); ns_y(3); ar_ns(2);
        ew_g(10, 0); ew_y(3); ar_ew(2);
        ns_g(10, 0); ns_y(3); ar_ns(2);
        run(3);
        ped_req_ns = 1'b1;
        run(1);
        ped_req_ns = 1'b0;
        run(65);

        // flash at EW_G timer 3, with a request latched while flashing
        ew_g(4, 0); ew_y(3); ar_ew(2);
        fl(1, 2); fl(0, 2); fl(1, 2); fl(0, 2);
        run(4);
        flash_en = 1'b1;
        run(9);
        ped_req_ew = 1'b1;
        run(1);
        ped_req_ew = 1'b0;
        run(3);

        // leave flash; latched EW request shortens NS_G
        ar_ew(2); ns_g(4, 0); ns_y(1);
        flash_en = 1'b0;
        run(7);

        // async reset mid NS_Y drops pending requests
        #2 rst = 1'b1;
        #1;
        check("rst_mid", obs(), {3'd5, R, R, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        ar_ew(1); ns_g(10, 0); ns_y(1);
        run(12);

        total++;
        assert (q.size() == 0) else begin
            bad++;
            $error("FAIL leftover got=%0d exp=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
